// File: rtl/seq_0101_pkg.sv
// Shared types for the 0101 serial pattern detector.
// Optional match counter is enabled with SEQ_0101_MATCH_CNT_EN.
package seq_0101_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_0    = 2'd1,
    S_01   = 2'd2,
    S_010  = 2'd3
  } state_e;

endpackage

// File: rtl/seq_0101.sv
// Mealy detector for the serial pattern 0-1-0-1 (first bit first).
// Define SEQ_0101_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_0101
  import seq_0101_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
`ifdef SEQ_0101_MATCH_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic dout
`ifdef SEQ_0101_MATCH_CNT_EN
  , output logic [CNT_W-1:0] match_cnt
`endif
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = in ? S_IDLE : S_0;
      S_0:    state_d = in ? S_01   : S_0;
      S_01:   state_d = in ? S_IDLE : S_010;
      // A completed match keeps its trailing "01" only when overlapping
      S_010:  state_d = in ? (OVERLAP ? S_01 : S_IDLE) : S_0;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dout = 1'b0;
    case (state_q)
      S_010:   dout = in & ~rst;
      default: dout = 1'b0;
    endcase
  end

`ifdef SEQ_0101_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dout && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_0101.sv
// Directed vector bench for seq_0101 (overlap and non-overlap instances).
// Counter checks are active when SEQ_0101_MATCH_CNT_EN is defined.
module tb_seq_0101;

  typedef struct {
    logic r;
    logic b;
    logic e_ov;
    logic e_no;
  } vec_t;

  logic clk;
  logic rst;
  logic din;
  logic dout_ov;
  logic dout_no;
`ifdef SEQ_0101_MATCH_CNT_EN
  logic [1:0] cnt_ov;
  logic [1:0] cnt_no;
`endif

  int nvec;
  int nerr;
  vec_t vq[$];

  seq_0101 #(
    .OVERLAP(1'b1)
`ifdef SEQ_0101_MATCH_CNT_EN
    , .CNT_W(2)
`endif
  ) u_ov (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .dout(dout_ov)
`ifdef SEQ_0101_MATCH_CNT_EN
    , .match_cnt(cnt_ov)
`endif
  );

  seq_0101 #(
    .OVERLAP(1'b0)
`ifdef SEQ_0101_MATCH_CNT_EN
    , .CNT_W(2)
`endif
  ) u_no (
    .clk (clk),
    .rst (rst),
    .in  (din),
    .dout(dout_no)
`ifdef SEQ_0101_MATCH_CNT_EN
    , .match_cnt(cnt_no)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic b,
                     input logic eo, input logic en);
    vec_t v;
    v.r = r;
    v.b = b;
    v.e_ov = eo;
    v.e_no = en;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [1:0] act,
                         input logic [1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    din = b;
    #1;
  endtask

  initial begin
    logic [1:0] mcnt_ov;
    logic [1:0] mcnt_no;
    bit cnt_ok;
    int np;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    din = 1'b1;
    mcnt_ov = '0;
    mcnt_no = '0;
    cnt_ok = 1'b0;

    // reset with in=1, then one idle cycle with in=1
    add(1, 1, 0, 0);
    add(0, 1, 0, 0);
    // stream 1,1,0,1,0,1,0,1,0,0
    add(0, 1, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 1, 1);
    add(0, 0, 0, 0);
    add(0, 1, 1, 0);
    add(0, 0, 0, 0);
    add(0, 0, 0, 0);
    // near misses from a clean state: 0,1,1,0,1,0,0,1
    add(1, 0, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    // clean 0101
    add(1, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 1, 1);
    // mid-sequence reset: 0,1,0, rst, then 1
    add(1, 0, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(1, 1, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 0, 0);
    add(0, 0, 0, 0);
    add(0, 1, 1, 1);

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].b);
      chk($sformatf("v%0d_ov", i), dout_ov, vq[i].e_ov);
      chk($sformatf("v%0d_no", i), dout_no, vq[i].e_no);
`ifdef SEQ_0101_MATCH_CNT_EN
      if (cnt_ok) begin
        chk_cnt($sformatf("v%0d_cnt_ov", i), cnt_ov, mcnt_ov);
        chk_cnt($sformatf("v%0d_cnt_no", i), cnt_no, mcnt_no);
      end
`endif
      @(posedge clk);
      if (vq[i].r) begin
        mcnt_ov = '0;
        mcnt_no = '0;
        cnt_ok = 1'b1;
      end else begin
        if (vq[i].e_ov && mcnt_ov != 2'd3) mcnt_ov++;
        if (vq[i].e_no && mcnt_no != 2'd3) mcnt_no++;
      end
    end

    // five overlapping matches, counter saturates at 3
    drive(1, 0);
    chk("sat_rst_ov", dout_ov, 1'b0);
    @(posedge clk);
    np = 0;
    for (int k = 1; k <= 12; k++) begin
      drive(0, k[0] ? 1'b0 : 1'b1);
      chk($sformatf("sat_b%0d_ov", k), dout_ov,
          (k >= 4 && k % 2 == 0));
      chk($sformatf("sat_b%0d_no", k), dout_no,
          (k % 4 == 0));
      @(posedge clk);
      #1;
      if (k >= 4 && k % 2 == 0) begin
        np++;
`ifdef SEQ_0101_MATCH_CNT_EN
        chk_cnt($sformatf("sat_cnt%0d", np), cnt_ov,
                (np > 3) ? 2'd3 : 2'(np));
`endif
      end
    end
`ifdef SEQ_0101_MATCH_CNT_EN
    chk_cnt("sat_cnt_no", cnt_no, 2'd3);
`endif
    drive(1, 1);
    chk("sat_rst_dout", dout_ov, 1'b0);
    @(posedge clk);
    #1;
`ifdef SEQ_0101_MATCH_CNT_EN
    chk_cnt("cnt_after_rst", cnt_ov, 2'd0);
`endif
    drive(0, 1);
    chk("post_rst_in1", dout_ov, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
